// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int TIMEOUT_DEF    = 64;  // cycles to wait for mDone before an error completion
    localparam int STARVE_MAX_DEF = 4;   // data grants allowed while a fetch waits

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and shared-memory signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are level-held until the matching one-cycle done pulse.
// Ports: master = arbiter view (drives done/data/memory strobes);
//        slave  = environment view (drives requests and memory responses).
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    // fetch port
    logic  iReq;
    word_t iAddr;
    word_t iDataOut;
    logic  iDone;
    logic  iErr;

    // data port
    logic  dRd;
    logic  dWr;
    word_t dAddr;
    word_t dDataIn;
    word_t dDataOut;
    logic  dDone;
    logic  dErr;

    // shared memory
    word_t mAddr;
    word_t mDataIn;
    logic  mRd;
    logic  mWr;
    word_t mDataOut;
    logic  mDone;
    logic  mErr;

    modport master (
        input  iReq, iAddr, dRd, dWr, dAddr, dDataIn, mDataOut, mDone, mErr,
        output iDataOut, iDone, iErr, dDataOut, dDone, dErr, mAddr, mDataIn, mRd, mWr
    );

    modport slave (
        output iReq, iAddr, dRd, dWr, dAddr, dDataIn, mDataOut, mDone, mErr,
        input  iDataOut, iDone, iErr, dDataOut, dDone, dErr, mAddr, mDataIn, mRd, mWr
    );

endinterface

// File: rtl/arb_timeout_cnt.sv
// Cycle counter bounding how long the arbiter waits for the memory.
// Latency: tc is combinational from the count; the count updates each rising edge.
// Backpressure: none; holds at terminal count until cleared.
// Ports: clr zeroes the count, en advances it, tc flags count == TIMEOUT-1.
module arb_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q;

    assign tc = (cnt_q == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory, with a starvation guard and timeout.
// Latency: memory latency + 2 cycles (grant cycle + response cycle); illegal rd+wr completes next cycle.
// Backpressure: requests are held until done; one transaction in flight, no queuing.
// Ports: clk, rst (sync, active-high); bus = mem_arbiter_if.master carrying both client ports and the memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_t    state_q, state_d;
    word_t         addr_q, wdata_q, idata_q, ddata_q;
    logic          resp_d_q;   // transaction belongs to the data port
    logic          err_q;
    logic [SW-1:0] starve_q;

    logic  grant_i, grant_d, illegal;
    logic  busy, tc, starved, resp;
    word_t sel_addr;

    assign busy     = (state_q == I_BUSY) || (state_q == D_BUSY);
    assign starved  = bus.iReq && (starve_q == SW'(STARVE_MAX));
    assign sel_addr = grant_d ? bus.dAddr : bus.iAddr;

    arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (!busy),
        .en  (busy),
        .tc  (tc)
    );

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        illegal = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are combinational in IDLE; rst gates them so outputs stay 0 in reset.
                if (!rst) begin
                    if (starved) begin
                        grant_i = 1'b1;
                    end else if (bus.dRd && bus.dWr) begin
                        illegal = 1'b1;
                    end else if (bus.dRd || bus.dWr) begin
                        grant_d = 1'b1;
                    end else if (bus.iReq) begin
                        grant_i = 1'b1;
                    end
                end
                if (grant_i) begin
                    state_d = I_BUSY;
                end else if (grant_d) begin
                    state_d = D_BUSY;
                end else if (illegal) begin
                    state_d = RESP;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.mDone || tc) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            idata_q  <= '0;
            ddata_q  <= '0;
            resp_d_q <= 1'b0;
            err_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q <= state_d;

            if (grant_i || grant_d) begin
                addr_q   <= sel_addr;
                wdata_q  <= grant_d ? bus.dDataIn : '0;
                resp_d_q <= grant_d;
                err_q    <= 1'b0;
            end else if (illegal) begin
                resp_d_q <= 1'b1;
                err_q    <= 1'b1;
            end

            // mDone beats a same-cycle timeout; a timeout leaves the port data untouched.
            if (busy && bus.mDone) begin
                err_q <= bus.mErr;
                if (resp_d_q) begin
                    ddata_q <= bus.mDataOut;
                end else begin
                    idata_q <= bus.mDataOut;
                end
            end else if (busy && tc) begin
                err_q <= 1'b1;
            end

            if (!bus.iReq || grant_i) begin
                starve_q <= '0;
            end else if (grant_d && (starve_q != SW'(STARVE_MAX))) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

    assign resp = (state_q == RESP) && !rst;

    assign bus.mRd      = grant_i || (grant_d && bus.dRd);
    assign bus.mWr      = grant_d && bus.dWr;
    assign bus.mAddr    = (grant_i || grant_d) ? sel_addr : addr_q;
    assign bus.mDataIn  = grant_d ? bus.dDataIn : (grant_i ? '0 : wdata_q);
    assign bus.iDone    = resp && !resp_d_q;
    assign bus.dDone    = resp && resp_d_q;
    assign bus.iErr     = bus.iDone && err_q;
    assign bus.dErr     = bus.dDone && err_q;
    assign bus.iDataOut = idata_q;
    assign bus.dDataOut = ddata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a cycle-numbered transaction model.
// Latency: checks completions land at grant + memory latency + 1 (timeouts at grant + TIMEOUT + 1).
// Backpressure: clients hold requests until their done pulse, occasionally dropping early.
module tb_mem_arbiter;

    localparam int TIMEOUT    = 64;
    localparam int STARVE_MAX = 4;
    localparam int N_CYC      = 4000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    // Transaction model: one job in flight, described by the cycle numbers of its events.
    bit          busy = 0;
    bit          port_d = 0;
    int          resp_cyc = 0;
    int          mdone_cyc = -1;
    bit          exp_err = 0;
    bit          upd_data = 0;
    logic [15:0] mem_dat = '0;
    logic        mem_err = 1'b0;
    logic [15:0] addr_exp = '0, wdat_exp = '0;
    logic [15:0] idata_exp = '0, ddata_exp = '0;
    int          starve = 0;
    bit          force_to = 0;
    bit          i_done_f = 0, d_done_f = 0;
    int          rst_state = 0;
    int          n_starve_grants = 0, n_timeouts = 0, n_illegal = 0;

    task automatic check_ctl_zero(input string tag);
        check({tag, "_mRd"},  32'(bus.mRd),  0);
        check({tag, "_mWr"},  32'(bus.mWr),  0);
        check({tag, "_iDone"}, 32'(bus.iDone), 0);
        check({tag, "_dDone"}, 32'(bus.dDone), 0);
        check({tag, "_iErr"}, 32'(bus.iErr), 0);
        check({tag, "_dErr"}, 32'(bus.dErr), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_ctl_zero(tag);
        check({tag, "_mAddr"},    32'(bus.mAddr),    0);
        check({tag, "_mDataIn"},  32'(bus.mDataIn),  0);
        check({tag, "_iDataOut"}, 32'(bus.iDataOut), 0);
        check({tag, "_dDataOut"}, 32'(bus.dDataOut), 0);
    endtask

    initial begin
        bit g_i, g_d, ill;
        bit e_mrd, e_mwr, e_idone, e_ddone, e_ierr, e_derr;
        bit active_i, active_d;
        int lat, p_d;

        rst = 1'b1;
        bus.iReq = 0; bus.iAddr = '0;
        bus.dRd = 0; bus.dWr = 0; bus.dAddr = '0; bus.dDataIn = '0;
        bus.mDataOut = '0; bus.mDone = 0; bus.mErr = 0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");

        for (int c = 0; c < N_CYC; c++) begin
            @(negedge clk);
            cyc = c;
            if (c == 200) force_to = 1;

            // Mid-transaction reset, taken once while a data job is in its BUSY phase.
            if (rst_state == 0 && c >= 2500 && busy && port_d && c < resp_cyc) rst_state = 1;
            if (rst_state == 1 || rst_state == 2) begin
                rst = 1'b1;
                bus.iReq = 0; bus.dRd = 0; bus.dWr = 0;
                bus.mDone = (rst_state == 2);
                bus.mErr = 0;
                bus.mDataOut = 16'($urandom);
                #1;
                if (rst_state == 1) check_ctl_zero("rst_busy");
                else check_all_zero("rst_hold");
                busy = 0; starve = 0; idata_exp = '0; ddata_exp = '0;
                i_done_f = 0; d_done_f = 0;
                rst_state++;
                continue;
            end
            rst = 1'b0;

            // Memory: real completion on schedule, otherwise junk and stray mDone pulses outside BUSY.
            bus.mDone = 0;
            bus.mErr = 1'($urandom);
            bus.mDataOut = 16'($urandom);
            if (busy && c == mdone_cyc) begin
                bus.mDone = 1; bus.mErr = mem_err; bus.mDataOut = mem_dat;
            end else if ((!busy || c >= resp_cyc) && $urandom_range(0, 7) == 0) begin
                bus.mDone = 1;
            end

            if (rst_state == 3) begin
                bus.iReq = 0; bus.dRd = 0; bus.dWr = 0;
                bus.mDone = 1;
                rst_state = 4;
            end else begin
                p_d = (c < N_CYC / 2) ? 8 : 15;
                active_i = busy && !port_d;
                active_d = busy && port_d;
                if (i_done_f) bus.iReq = 0;
                if (d_done_f) begin bus.dRd = 0; bus.dWr = 0; end
                i_done_f = 0; d_done_f = 0;
                if (active_i && bus.iReq && $urandom_range(0, 15) == 0) bus.iReq = 0;
                if (active_d && (bus.dRd || bus.dWr) && $urandom_range(0, 15) == 0) begin
                    bus.dRd = 0; bus.dWr = 0;
                end
                if (!bus.iReq || active_i) bus.iAddr = 16'($urandom);
                if (!(bus.dRd || bus.dWr) || active_d) begin
                    bus.dAddr = 16'($urandom);
                    bus.dDataIn = 16'($urandom);
                end
                if (!bus.iReq && !active_i && $urandom_range(0, 3) == 0) bus.iReq = 1;
                if (!(bus.dRd || bus.dWr) && !active_d && $urandom_range(0, 15) < p_d) begin
                    lat = $urandom_range(0, 31);
                    if (lat == 0) begin bus.dRd = 1; bus.dWr = 1; end
                    else if (lat < 16) bus.dRd = 1;
                    else bus.dWr = 1;
                end
            end

            #1;
            g_i = 0; g_d = 0; ill = 0;
            e_mrd = 0; e_mwr = 0; e_idone = 0; e_ddone = 0; e_ierr = 0; e_derr = 0;

            if (!busy) begin
                if (bus.iReq && starve == STARVE_MAX) g_i = 1;
                else if (bus.dRd && bus.dWr) ill = 1;
                else if (bus.dRd || bus.dWr) g_d = 1;
                else if (bus.iReq) g_i = 1;
            end

            if (g_i) begin
                e_mrd = 1;
                if (starve == STARVE_MAX) n_starve_grants++;
                check("grant_i_mAddr", 32'(bus.mAddr), 32'(bus.iAddr));
                check("grant_i_mDataIn", 32'(bus.mDataIn), 0);
            end
            if (g_d) begin
                e_mrd = bus.dRd; e_mwr = bus.dWr;
                check("grant_d_mAddr", 32'(bus.mAddr), 32'(bus.dAddr));
                check("grant_d_mDataIn", 32'(bus.mDataIn), 32'(bus.dDataIn));
            end
            if (busy && c < resp_cyc) begin
                check("busy_mAddr_hold", 32'(bus.mAddr), 32'(addr_exp));
                check("busy_mDataIn_hold", 32'(bus.mDataIn), 32'(wdat_exp));
            end
            if (busy && c == resp_cyc) begin
                if (port_d) begin
                    e_ddone = 1; e_derr = exp_err;
                    if (upd_data) ddata_exp = mem_dat;
                end else begin
                    e_idone = 1; e_ierr = exp_err;
                    if (upd_data) idata_exp = mem_dat;
                end
            end

            check("mRd", 32'(bus.mRd), 32'(e_mrd));
            check("mWr", 32'(bus.mWr), 32'(e_mwr));
            check("iDone", 32'(bus.iDone), 32'(e_idone));
            check("dDone", 32'(bus.dDone), 32'(e_ddone));
            check("iErr", 32'(bus.iErr), 32'(e_ierr));
            check("dErr", 32'(bus.dErr), 32'(e_derr));
            check("iDataOut", 32'(bus.iDataOut), 32'(idata_exp));
            check("dDataOut", 32'(bus.dDataOut), 32'(ddata_exp));

            // Advance the model to the next cycle.
            if (busy && c == resp_cyc) begin
                busy = 0;
                if (port_d) d_done_f = 1; else i_done_f = 1;
            end
            if (g_i || g_d) begin
                busy = 1; port_d = g_d;
                addr_exp = g_d ? bus.dAddr : bus.iAddr;
                wdat_exp = g_d ? bus.dDataIn : 16'h0000;
                lat = $urandom_range(0, 63);
                if (force_to || lat == 0) begin
                    mdone_cyc = -1; resp_cyc = c + TIMEOUT + 1;
                    exp_err = 1; upd_data = 0; force_to = 0;
                    n_timeouts++;
                end else begin
                    if (lat == 1) lat = TIMEOUT;
                    else if (lat == 2) lat = TIMEOUT - 1;
                    else lat = $urandom_range(1, 6);
                    mdone_cyc = c + lat; resp_cyc = c + lat + 1;
                    mem_err = ($urandom_range(0, 7) == 0);
                    mem_dat = 16'($urandom);
                    exp_err = mem_err; upd_data = 1;
                end
            end
            if (ill) begin
                busy = 1; port_d = 1; resp_cyc = c + 1; mdone_cyc = -1;
                exp_err = 1; upd_data = 0;
                n_illegal++;
            end
            if (!bus.iReq || g_i) starve = 0;
            else if (g_d && starve < STARVE_MAX) starve++;
        end

        check("reached_mid_txn_reset", 32'(rst_state), 4);
        check("reached_starve_grant", 32'(n_starve_grants > 0), 1);
        check("reached_timeout", 32'(n_timeouts > 0), 1);
        check("reached_illegal", 32'(n_illegal > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
